bubble_sort4_ctrl: RTL
======================

// Module: bubble_sort4_ctrl
// PURPOSE
//  Sequencer that sorts four 4-bit values by time-sharing ONE 4-bit magnitude comparator.
//  Latches a 16-bit vector on start, runs a bubble sort one compare/swap per clock,
//  and presents the sorted vector with a one-cycle done pulse. Sits between a
//  register-file/switch front end and display logic in the lab top level.
// PARAMETERS
//  EARLY_EXIT  1  1: stop after the first pass with no swap; 0: always run all 6 compares
// PORTS
//  clk    in   1   system clock, all state changes on posedge
//  rst_n  in   1   synchronous active-low reset
//  start  in   1   request sort; sampled only in IDLE
//  desc   in   1   0 = ascending, 1 = descending; latched with din on start
//  din    in   16  elements e0..e3, e[i] = din[4i+3:4i]
//  busy   out  1   high in SORT and DONE
//  done   out  1   one-cycle pulse, dout valid from this cycle
//  dout   out  16  sorted elements, same packing; held until next accepted start
//  swaps  out  3   number of swaps performed in the last sort (0..6)
// BEHAVIOUR
//  - Reset: rst_n=0 at posedge -> state IDLE; element regs, dout, swaps = 0; busy = done = 0.
//    Reset wins over every other event, including mid-SORT; any partial sort is discarded.
//  - States: IDLE -> SORT -> DONE -> IDLE.
//    IDLE: start=1 -> latch din, desc; pass=0, idx=0, swapped=0, swaps=0; go SORT.
//          start=0 -> stay. dout/swaps keep old values.
//    SORT: each cycle the comparator sees a=r[idx], b=r[idx+1].
//          asc: swap if a_gt_b. desc: swap if a_lt_b. a_eq_b never swaps (stable).
//          On swap: exchange the two regs, swaps+1, swapped=1.
//          Pass p compares idx = 0..2-p (3, 2, 1 compares).
//          End of pass, i.e. idx == 2-p: evaluate swapped, including this cycle's swap.
//            If p == 2, or EARLY_EXIT=1 and swapped == 0 -> DONE.
//            Otherwise p+1, idx=0, swapped=0.
//    DONE: done=1 for exactly this cycle; dout = element regs; unconditionally -> IDLE.
//  - Latency: start edge E0; N compare cycles; done high in the cycle after edge E0+N.
//    N = 6 max. N = 3 minimum, for already-sorted input with EARLY_EXIT=1.
//  - start while busy: ignored, no queueing. din/desc changes during SORT: no effect.
//  - Comparator is combinational; the compare and swap complete in the same cycle, with no
//    extra pipeline stage. Operand mux selects by idx only (2-bit).
//  - swaps saturates naturally: the max of 6 fits in 3 bits, with no wrap.
// STRUCTURE
//  - One sub-module: a single instance of the team's existing 4-bit comparator (lt/gt/eq
//    outputs) fed by the operand mux. No other comparators are permitted.
//  - State encoding and pass/idx limits are localparams in this file.
//  - No shared package is needed. If the display block later consumes them, the element width
//    and count (4, 4) go into the shared lab defines include.
// TESTING
//  1 Reset: hold rst_n=0 for 2 clocks with start=1 -> busy=0, done=0, dout=16'h0000, swaps=0.
//  2 Sorted asc, e0..e3 = 1,2,3,4, desc=0 -> dout=16'h4321, swaps=0.
//    done at E0+4 with EARLY_EXIT=1; at E0+7 with EARLY_EXIT=0.
//  3 Reverse, e = 9,7,3,0, desc=0 -> dout=16'h9730, i.e. e0=0 .. e3=9; swaps=6; done at E0+7.
//  4 Duplicates, e = F,0,F,0 -> dout=16'hFF00, swaps=3, done at E0+7.
//    Equal pair never swapped; verify via swaps count.
//  5 Descending, e = 1,2,3,4, desc=1 -> dout=16'h1234, i.e. e0=4; swaps=6.
//    Raise start again during SORT -> ignored: single done, result unchanged.
//  6 Reset mid-sort: rst_n=0 at E0+2 of a reverse-input sort.
//    -> next cycle IDLE, dout=0, no done pulse. A fresh start then completes normally.

Source files
------------

// File: rtl/bubble_sort4_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// bubble_sort4_ctrl_pkg
//   Shared element types for the four-element bubble sorter and its
//   comparator. The packed vector type maps one-to-one onto the 16-bit bus
//   packing used at the ports: element i occupies bits [4i+3:4i].
// ----------------------------------------------------------------------------
package bubble_sort4_ctrl_pkg;

   localparam int ELEM_W = 4;
   localparam int ELEM_N = 4;

   typedef logic [ELEM_W-1:0] elem_t;
   typedef elem_t [ELEM_N-1:0] elem_vec_t;

   // Swap decision for one adjacent pair (a sits at the lower index).
   // Equal operands never swap, which keeps the sort stable.
   function automatic logic need_swap(input logic desc,
                                      input logic a_lt_b,
                                      input logic a_gt_b,
                                      input logic a_eq_b);
      return !a_eq_b && (desc ? a_lt_b : a_gt_b);
   endfunction

endpackage : bubble_sort4_ctrl_pkg

// File: rtl/bubble_sort4_ctrl_cmp.sv
// ----------------------------------------------------------------------------
// bubble_sort4_ctrl_cmp
//   Purely combinational 4-bit unsigned magnitude comparator.
//   Ports:
//     a, b    in   4   operands
//     a_lt_b  out  1   a <  b
//     a_gt_b  out  1   a >  b
//     a_eq_b  out  1   a == b
// ----------------------------------------------------------------------------
module bubble_sort4_ctrl_cmp
   import bubble_sort4_ctrl_pkg::*;
(
   input  logic [ELEM_W-1:0] a,
   input  logic [ELEM_W-1:0] b,
   output logic              a_lt_b,
   output logic              a_gt_b,
   output logic              a_eq_b
);

   assign a_lt_b = (a <  b);
   assign a_gt_b = (a >  b);
   assign a_eq_b = (a == b);

endmodule : bubble_sort4_ctrl_cmp

// File: rtl/bubble_sort4_ctrl.sv
// ----------------------------------------------------------------------------
// bubble_sort4_ctrl
//   Sorts four 4-bit values with a bubble sort that time-shares a single
//   magnitude comparator: one compare/swap per clock. The input vector and
//   direction are latched on an accepted start; the sorted vector appears on
//   dout together with a one-cycle done pulse and is held until the next
//   accepted start.
//
//   Parameters:
//     EARLY_EXIT  1: finish after the first pass with no swap
//                 0: always run all six compares
//   Ports:
//     clk    in   1   system clock, all state changes on posedge
//     rst_n  in   1   synchronous active-low reset
//     start  in   1   sort request, only sampled in IDLE
//     desc   in   1   0 = ascending, 1 = descending (latched with din)
//     din    in   16  elements e0..e3, e[i] = din[4i+3:4i]
//     busy   out  1   high in SORT and DONE
//     done   out  1   one-cycle pulse, dout valid from this cycle
//     dout   out  16  sorted elements, same packing as din
//     swaps  out  3   swaps performed by the last sort (0..6)
// ----------------------------------------------------------------------------
module bubble_sort4_ctrl
   import bubble_sort4_ctrl_pkg::*;
#(
   parameter bit EARLY_EXIT = 1'b1
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        desc,
   input  logic [15:0] din,
   output logic        busy,
   output logic        done,
   output logic [15:0] dout,
   output logic [2:0]  swaps
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_SORT = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // Pass p compares idx = 0 .. LAST_IDX - p; the final pass is LAST_PASS.
   localparam logic [1:0] LAST_PASS = 2'd2;
   localparam logic [1:0] LAST_IDX  = 2'd2;

   state_t     state_q, state_d;
   elem_vec_t  elem_q,  elem_d;
   elem_vec_t  dout_q,  dout_d;
   logic       desc_q,  desc_d;
   logic [1:0] pass_q,  pass_d;
   logic [1:0] idx_q,   idx_d;
   logic       swapped_q, swapped_d;
   logic [2:0] swaps_q, swaps_d;

   // Comparator operand mux and decision signals.
   logic [1:0] idx_hi;
   elem_t      op_a, op_b;
   logic       a_lt_b, a_gt_b, a_eq_b;
   logic       do_swap;
   logic       pass_end;
   logic       swapped_any;
   logic       sort_end;

   assign idx_hi = idx_q + 2'd1;
   assign op_a   = elem_q[idx_q];
   assign op_b   = elem_q[idx_hi];

   bubble_sort4_ctrl_cmp u_cmp (
      .a      (op_a),
      .b      (op_b),
      .a_lt_b (a_lt_b),
      .a_gt_b (a_gt_b),
      .a_eq_b (a_eq_b)
   );

   assign do_swap     = need_swap(desc_q, a_lt_b, a_gt_b, a_eq_b);
   assign pass_end    = (idx_q == (LAST_IDX - pass_q));
   // The end-of-pass decision must include the swap made in this very cycle.
   assign swapped_any = swapped_q | do_swap;
   assign sort_end    = pass_end &&
                        ((pass_q == LAST_PASS) || (EARLY_EXIT && !swapped_any));

   // ------------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before the case so no path can
      // leave one unassigned and infer a latch.
      state_d   = state_q;
      elem_d    = elem_q;
      dout_d    = dout_q;
      desc_d    = desc_q;
      pass_d    = pass_q;
      idx_d     = idx_q;
      swapped_d = swapped_q;
      swaps_d   = swaps_q;
      busy      = 1'b0;
      done      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               elem_d    = elem_vec_t'(din);
               desc_d    = desc;
               pass_d    = 2'd0;
               idx_d     = 2'd0;
               swapped_d = 1'b0;
               swaps_d   = 3'd0;
               state_d   = ST_SORT;
            end
         end

         ST_SORT: begin
            busy = 1'b1;
            if (do_swap) begin
               elem_d[idx_q]  = op_b;
               elem_d[idx_hi] = op_a;
               swaps_d        = swaps_q + 3'd1;
            end
            if (sort_end) begin
               // NOTE: blocking assignments in a combinational block execute in
               // order, so dout_d sees this cycle's swap already applied to
               // elem_d; that is what makes dout valid in the DONE cycle.
               dout_d  = elem_d;
               state_d = ST_DONE;
            end else if (pass_end) begin
               pass_d    = pass_q + 2'd1;
               idx_d     = 2'd0;
               swapped_d = 1'b0;
            end else begin
               idx_d     = idx_q + 2'd1;
               swapped_d = swapped_any;
            end
         end

         ST_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the element registers are a tiny register bank, not a RAM, and
         // a reset mid-sort must discard the partial result, so they are reset
         // along with everything else.
         elem_q    <= '0;
         dout_q    <= '0;
         desc_q    <= 1'b0;
         pass_q    <= 2'd0;
         idx_q     <= 2'd0;
         swapped_q <= 1'b0;
         swaps_q   <= 3'd0;
      end else begin
         elem_q    <= elem_d;
         dout_q    <= dout_d;
         desc_q    <= desc_d;
         pass_q    <= pass_d;
         idx_q     <= idx_d;
         swapped_q <= swapped_d;
         swaps_q   <= swaps_d;
      end
   end

   assign dout  = dout_q;
   assign swaps = swaps_q;

endmodule : bubble_sort4_ctrl
